// File: rtl/pmu_pkg.sv
// pmu_pkg: shared states, error-bit indices and default destination map for the PMU frame router.
package pmu_pkg;
  typedef enum logic {SHIFT, HOLD} state_t;
  localparam int ERR_LEN = 0;
  localparam int ERR_OVR = 1;
  localparam int ERR_DEST = 2;
  localparam int DEST_SCAN = 0;
  localparam int DEST_MEM = 1;
  localparam int DEST_AES = 2;
  localparam int DEST_KEY = 3;
endpackage

// File: rtl/piso_readback.sv
// piso_readback: parallel-load, LSB-first serial readback of a memory word.
module piso_readback #(
  parameter int MEM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [MEM_W-1:0] mem_data,
  output logic             sdo
);
  logic [MEM_W-1:0] rb;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rb <= '0;
    else if (load) rb <= mem_data;
    else if (shift) rb <= rb >> 1;
  assign sdo = rb[0];
endmodule

// File: rtl/sipo_router_param.sv
// sipo_router_param: accumulates an LSB-first bitstream into a frame and hands it to
// one of NUM_DEST destinations over a valid/ready handshake, with sticky error flags.
module sipo_router_param
  import pmu_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int MEM_W    = 32,
  parameter int NUM_DEST = 4,
  parameter int MEM_DEST = DEST_MEM,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                data_i,
  input  logic                send,
  input  logic [SEL_W-1:0]    instruction,
  output logic [DATA_W-1:0]   data_o,
  output logic [NUM_DEST-1:0] dest_valid_o,
  input  logic [NUM_DEST-1:0] dest_ready_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    bit_cnt_o,
  output logic [2:0]          err_o,
  input  logic                err_clr_i,
  input  logic                rb_load_i,
  input  logic                rb_shift_i,
  input  logic [MEM_W-1:0]    mem_data_i,
  output logic                sdo_o
);
  state_t state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, data_n;
  logic [NUM_DEST-1:0] valid_n;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0] err_n, err_set;
  logic is_mem, bad_dest, full;
  logic [CNT_W-1:0] req_len;
  assign is_mem   = int'(instruction) == MEM_DEST;
  assign bad_dest = int'(instruction) >= NUM_DEST;
  assign req_len  = is_mem ? CNT_W'(MEM_W) : CNT_W'(DATA_W);
  assign full     = bit_cnt_o == CNT_W'(DATA_W);
  assign busy_o   = state == HOLD;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = bit_cnt_o;
    data_n  = data_o;
    valid_n = dest_valid_o;
    err_set = '0;
    if (state == SHIFT) begin
      if (send) begin
        err_set[ERR_OVR] = en;
        shreg_n = '0;
        cnt_n   = '0;
        if (bad_dest) err_set[ERR_DEST] = 1'b1;
        else if (bit_cnt_o != req_len) err_set[ERR_LEN] = 1'b1;
        else begin
          state_n = HOLD;
          shreg_n = shreg;
          cnt_n   = bit_cnt_o;
          // memory frames were shifted in from the top, so their word sits in the upper bits
          data_n  = is_mem ? DATA_W'(shreg[DATA_W-1 -: MEM_W]) : shreg;
          valid_n = NUM_DEST'(1) << instruction;
        end
      end else if (en) begin
        if (full) err_set[ERR_OVR] = 1'b1;
        else begin
          shreg_n = {data_i, shreg[DATA_W-1:1]};
          cnt_n   = bit_cnt_o + CNT_W'(1);
        end
      end
    end else begin
      err_set[ERR_OVR] = en;
      if (|(dest_valid_o & dest_ready_i)) begin
        state_n = SHIFT;
        valid_n = '0;
        shreg_n = '0;
        cnt_n   = '0;
      end
    end
    err_n = (err_o & {3{~err_clr_i}}) | err_set;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= SHIFT;
      shreg        <= '0;
      data_o       <= '0;
      dest_valid_o <= '0;
      bit_cnt_o    <= '0;
      err_o        <= '0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      data_o       <= data_n;
      dest_valid_o <= valid_n;
      bit_cnt_o    <= cnt_n;
      err_o        <= err_n;
    end
  piso_readback #(.MEM_W(MEM_W)) u_rb (
    .clk      (clk),
    .rst      (rst),
    .load     (rb_load_i),
    .shift    (rb_shift_i),
    .mem_data (mem_data_i),
    .sdo      (sdo_o)
  );
endmodule

// File: tb/tb_sipo_router_param.sv
// tb_sipo_router_param: directed and randomized frames scored against a queue of expected transfers.
module tb_sipo_router_param;
  import pmu_pkg::*;
  logic clk = 1'b0;
  logic rst, en, data_i, send, err_clr_i, rb_load_i, rb_shift_i, sdo_o, busy_o;
  logic [1:0] instruction;
  logic [127:0] data_o;
  logic [3:0] dest_valid_o, dest_ready_i;
  logic [7:0] bit_cnt_o;
  logic [2:0] err_o, exp_err;
  logic [31:0] mem_data_i;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [1:0] dest; logic [127:0] data;} exp_t;
  exp_t q[$];
  sipo_router_param dut (
    .clk(clk), .rst(rst), .en(en), .data_i(data_i), .send(send), .instruction(instruction),
    .data_o(data_o), .dest_valid_o(dest_valid_o), .dest_ready_i(dest_ready_i), .busy_o(busy_o),
    .bit_cnt_o(bit_cnt_o), .err_o(err_o), .err_clr_i(err_clr_i), .rb_load_i(rb_load_i),
    .rb_shift_i(rb_shift_i), .mem_data_i(mem_data_i), .sdo_o(sdo_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && |(dest_valid_o & dest_ready_i)) begin
      if (q.size() == 0) check("unexpected_transfer", 128'(dest_valid_o), 128'(0));
      else begin
        e = q.pop_front();
        check("xfer_valid", 128'(dest_valid_o), 128'(4'b1 << e.dest));
        check("xfer_data", data_o, e.data);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic shift_in(input logic [127:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1;
      data_i = w[i % 128];
      tick();
    end
    en = 1'b0;
  endtask
  task automatic send_to(input logic [1:0] d, input logic [3:0] rdy);
    instruction = d;
    dest_ready_i = rdy;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask
  function automatic logic [127:0] frame(input logic [1:0] d, input logic [127:0] w);
    return int'(d) == DEST_MEM ? {96'b0, w[31:0]} : w;
  endfunction
  task automatic expect_frame(input logic [1:0] d, input logic [127:0] w);
    exp_t e;
    e.dest = d;
    e.data = frame(d, w);
    q.push_back(e);
  endtask
  task automatic clear_err;
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_err = '0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [127:0] w;
    logic [3:0] oh;
    logic [1:0] d;
    int n, need, delay;
    logic good;
    rst = 1'b0; en = 1'b0; data_i = 1'b0; send = 1'b0; instruction = '0; dest_ready_i = '0;
    err_clr_i = 1'b0; rb_load_i = 1'b0; rb_shift_i = 1'b0; mem_data_i = '0; exp_err = '0;
    #25;
    check("rst_data", data_o, 128'(0));
    check("rst_valid", 128'(dest_valid_o), 128'(0));
    check("rst_cnt", 128'(bit_cnt_o), 128'(0));
    check("rst_err", 128'(err_o), 128'(0));
    check("rst_busy_sdo", 128'({busy_o, sdo_o}), 128'(0));
    @(posedge clk); #1 rst = 1'b1;
    tick();
    // scanchain frame, ready already high
    w = 128'h0123456789abcdef0123456789abcdef;
    shift_in(w, 128);
    check("scan_cnt", 128'(bit_cnt_o), 128'(128));
    expect_frame(2'd0, w);
    send_to(2'd0, 4'b0001);
    check("scan_valid", 128'(dest_valid_o), 128'(4'b0001));
    check("scan_busy", 128'(busy_o), 128'(1));
    tick();
    dest_ready_i = '0;
    check("scan_valid_drop", 128'(dest_valid_o), 128'(0));
    check("scan_cnt_clr", 128'(bit_cnt_o), 128'(0));
    check("scan_data_kept", data_o, w);
    // memory frame
    w = 128'hdeadbeef;
    shift_in(w, 32);
    expect_frame(2'd1, w);
    send_to(2'd1, 4'b0010);
    check("mem_data", data_o, {96'b0, 32'hdeadbeef});
    tick();
    dest_ready_i = '0;
    // backpressure on AES destination
    w = {$urandom, $urandom, $urandom, $urandom};
    shift_in(w, 128);
    expect_frame(2'd2, w);
    send_to(2'd2, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 128'(dest_valid_o), 128'(4'b0100));
      check("bp_data", data_o, w);
      check("bp_busy", 128'(busy_o), 128'(1));
      en = i[0];
      tick();
    end
    en = 1'b0;
    exp_err[ERR_OVR] = 1'b1;
    check("bp_err", 128'(err_o), 128'(exp_err));
    dest_ready_i = 4'b0100;
    tick();
    dest_ready_i = '0;
    check("bp_done_valid", 128'(dest_valid_o), 128'(0));
    check("bp_done_busy", 128'(busy_o), 128'(0));
    // length error
    clear_err();
    check("clr_err", 128'(err_o), 128'(0));
    shift_in({$urandom, $urandom, $urandom, $urandom}, 100);
    send_to(2'd0, 4'b0001);
    dest_ready_i = '0;
    check("len_valid", 128'(dest_valid_o), 128'(0));
    check("len_err", 128'(err_o), 128'(3'b001));
    check("len_cnt", 128'(bit_cnt_o), 128'(0));
    clear_err();
    // overrun saturates; clear with simultaneous new error keeps the new bit
    w = {$urandom, $urandom, $urandom, $urandom};
    shift_in(w, 129);
    check("ovr_cnt", 128'(bit_cnt_o), 128'(128));
    check("ovr_err", 128'(err_o), 128'(3'b010));
    err_clr_i = 1'b1;
    send_to(2'd1, 4'b0000);
    err_clr_i = 1'b0;
    check("clr_vs_new_err", 128'(err_o), 128'(3'b001));
    check("clr_vs_new_cnt", 128'(bit_cnt_o), 128'(0));
    clear_err();
    shift_in(w, 129);
    expect_frame(2'd0, w);
    send_to(2'd0, 4'b0001);
    tick();
    dest_ready_i = '0;
    clear_err();
    // reset during a stalled HOLD
    w = {$urandom, $urandom, $urandom, $urandom};
    shift_in(w, 128);
    expect_frame(2'd3, w);
    send_to(2'd3, 4'b0000);
    check("hold_valid", 128'(dest_valid_o), 128'(4'b1000));
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 128'(dest_valid_o), 128'(0));
    check("async_rst_busy", 128'(busy_o), 128'(0));
    q.delete();
    @(posedge clk); #1 rst = 1'b1;
    tick();
    w = {$urandom, $urandom, $urandom, $urandom};
    shift_in(w, 128);
    expect_frame(2'd0, w);
    send_to(2'd0, 4'b0001);
    tick();
    dest_ready_i = '0;
    // readback
    mem_data_i = 32'h0000000b;
    rb_load_i = 1'b1;
    tick();
    rb_load_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rb_sdo", 128'(sdo_o), 128'((32'hb >> i) & 1));
      rb_shift_i = 1'b1;
      tick();
      rb_shift_i = 1'b0;
    end
    mem_data_i = 32'h1;
    rb_load_i = 1'b1;
    rb_shift_i = 1'b1;
    tick();
    rb_load_i = 1'b0;
    rb_shift_i = 1'b0;
    check("rb_load_priority", 128'(sdo_o), 128'(1));
    // randomized frames against the model
    for (int k = 0; k < 24; k++) begin
      d = 2'($urandom_range(0, 3));
      oh = 4'b1 << d;
      need = int'(d) == DEST_MEM ? 32 : 128;
      good = $urandom_range(0, 4) != 0;
      n = good ? need : $urandom_range(1, 127);
      if (n == need && !good) n = need + 1;
      w = {$urandom, $urandom, $urandom, $urandom};
      shift_in(w, n);
      if (good) begin
        delay = $urandom_range(0, 3);
        expect_frame(d, w);
        send_to(d, delay == 0 ? oh : 4'b0000);
        for (int j = 0; j < delay; j++) begin
          check("rand_stall_valid", 128'(dest_valid_o), 128'(oh));
          tick();
        end
        dest_ready_i = oh;
        tick();
        dest_ready_i = '0;
        check("rand_done_valid", 128'(dest_valid_o), 128'(0));
      end else begin
        send_to(d, oh);
        dest_ready_i = '0;
        exp_err[ERR_LEN] = 1'b1;
        check("rand_len_valid", 128'(dest_valid_o), 128'(0));
        check("rand_len_err", 128'(err_o), 128'(exp_err));
      end
      check("rand_cnt", 128'(bit_cnt_o), 128'(0));
    end
    tick();
    check("queue_drained", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sipo_router_param.md
Name: sipo_router_param

Overview:
- Parametrised serial-in/parallel-out frame router for the PMU.
- Accumulates an LSB-first bitstream from the programming interface into a frame.
- On a send strobe, delivers the frame to one of NUM_DEST destinations (scanchain, memory, AES data, AES key, ...) using a per-destination valid/ready handshake.
- Adds frame-length checking, backpressure, sticky error flags and a memory-word serial readback path, none of which the first-generation SIPO provides.

Parameters:
- DATA_W, 128, full frame width in bits.
- MEM_W, 32, frame width for the memory destination; must satisfy MEM_W <= DATA_W.
- NUM_DEST, 4, number of destinations.
- MEM_DEST, 1, index of the destination that uses MEM_W-bit frames; all others use DATA_W.
- SEL_W, 2, width of the destination select; must satisfy 2**SEL_W >= NUM_DEST.
- CNT_W, $clog2(DATA_W+1), bit-counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  data_i is valid this cycle.
- data_i  in  1  serial data bit, LSB of the frame first.
- send  in  1  one-cycle strobe: deliver the current frame.
- instruction  in  SEL_W  destination select; sampled only on send.
- data_o  out  DATA_W  parallel frame, stable while any valid is high.
- dest_valid_o  out  NUM_DEST  one-hot valid.
- dest_ready_i  in  NUM_DEST  per-destination ready.
- busy_o  out  1  high while in HOLD.
- bit_cnt_o  out  CNT_W  bits accumulated in the current frame.
- err_o  out  3  sticky errors: [0] length, [1] overrun, [2] bad destination.
- err_clr_i  in  1  clears err_o.
- rb_load_i  in  1  parallel-load mem_data_i into the readback register.
- rb_shift_i  in  1  shift the readback register one bit.
- mem_data_i  in  MEM_W  memory word for readback.
- sdo_o  out  1  readback serial out, always equal to readback register bit 0.

Behaviour:
Reset (rst low, asynchronous):
- shreg, data_o, dest_valid_o, bit_cnt_o, err_o and the readback register all clear to 0; state = SHIFT.
- Reset in any state, including HOLD, drops the frame and deasserts valid immediately.

States: SHIFT and HOLD.

SHIFT, en=1, send=0:
- shreg <= {data_i, shreg[DATA_W-1:1]}, bit_cnt +1.
- If bit_cnt == DATA_W already: no shift, err_o[1] set, counter saturates.

SHIFT, send=1:
- The en bit in the same cycle is discarded and err_o[1] is set if en=1; send has priority.
- Required length: MEM_W if instruction == MEM_DEST, else DATA_W.
- If instruction >= NUM_DEST: err_o[2] set; shreg and bit_cnt cleared; stay in SHIFT.
- Else if bit_cnt != required length: err_o[0] set; shreg and bit_cnt cleared; stay in SHIFT.
- Else, next cycle, enter HOLD:
  - data_o = shreg for DATA_W frames; {zeros, shreg[DATA_W-1 -: MEM_W]} for MEM_DEST.
  - dest_valid_o = one-hot(instruction); busy_o = 1.
  - Latency from send to valid is 1 cycle.

HOLD:
- data_o and dest_valid_o are held.
- en is ignored; a bit arriving on en sets err_o[1].
- send is ignored.
- When dest_valid_o & dest_ready_i is nonzero at a clock edge: the transfer completes. Next cycle valid = 0, busy_o = 0, bit_cnt = 0, shreg = 0, state = SHIFT.
- data_o keeps its last value after the transfer.
- If ready is already high on entry, HOLD lasts exactly 1 cycle.

Error flags:
- err_o bits are sticky.
- err_clr_i clears them; a simultaneous new error wins (the bit remains set).

Readback (independent of the state machine):
- rb_load_i: rb <= mem_data_i.
- else rb_shift_i: rb <= {1'b0, rb[MEM_W-1:1]}.
- sdo_o = rb[0]; load has priority over shift.

Decomposition:
- Shared package pmu_pkg:
  - state enum {SHIFT, HOLD}.
  - Error-bit index constants ERR_LEN=0, ERR_OVR=1, ERR_DEST=2.
  - Default destination indices DEST_SCAN=0, DEST_MEM=1, DEST_AES=2, DEST_KEY=3.
- One sub-module: piso_readback, parameter MEM_W, implementing the readback register.

Test Plan:
- Frame to scanchain: rst low then high; shift 128 bits of 128'h0123456789abcdef0123456789abcdef LSB first; send with instruction=0, dest_ready_i=4'b0001 -> one cycle later data_o matches the word, dest_valid_o=4'b0001 for 1 cycle, then bit_cnt_o=0.
- Memory frame: shift 32'hdeadbeef (32 bits), instruction=1 -> data_o = {96'b0, 32'hdeadbeef}, dest_valid_o=4'b0010.
- Backpressure: full AES frame, instruction=2, ready held low for 5 cycles -> valid and data_o stable for 5 cycles, busy_o=1. en pulses during the stall set err_o[1]. Raising ready completes the transfer on the next edge.
- Length error: 100 bits then send with instruction=0 -> no valid, err_o=3'b001, bit_cnt_o=0. err_clr_i -> err_o=0.
- Reset mid-HOLD: assert rst during a stalled HOLD -> dest_valid_o falls immediately. After release, a fresh 128-bit frame delivers correctly.
- Readback: rb_load_i with mem_data_i=32'h0000000b, then 4 shifts -> sdo_o sequence 1,1,0,1, then 0.
